sb_rx_msg_dispatcher: RTL and testbench

SB_RX_MSG_DISPATCHER -- requirements
Module: sb_rx_msg_dispatcher

---
 rtl/sb_rx_msg_dispatcher_pkg.sv | 30 +++
 rtl/sb_rx_msg_fifo.sv | 92 +++++++++
 rtl/sb_rx_msg_dispatcher.sv | 108 ++++++++++
 tb/tb_sb_rx_msg_dispatcher.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_rx_msg_dispatcher_pkg.sv
// Shared sideband receive types: LTSM/RDI message layouts, field widths,
// the default parity-drop counter width and the queue FSM encoding.
package sb_rx_msg_dispatcher_pkg;

  localparam int SB_MSG_NO_W       = 4;
  localparam int SB_MSG_INFO_W     = 3;
  localparam int SB_DATA_W         = 16;
  localparam int SB_RDI_CODE_W     = 2;
  localparam int SB_RDI_SUB_CODE_W = 4;
  localparam int SB_RDI_INFO_W     = 2;
  localparam int SB_PARITY_CNT_W   = 8;

  typedef struct packed {
    logic [SB_MSG_NO_W-1:0]   msg_no;
    logic [SB_MSG_INFO_W-1:0] msg_info;
    logic [SB_DATA_W-1:0]     data;
  } ltsm_msg_t;

  typedef struct packed {
    logic [SB_RDI_CODE_W-1:0]     code;
    logic [SB_RDI_SUB_CODE_W-1:0] sub_code;
    logic [SB_RDI_INFO_W-1:0]     info;
  } rdi_msg_t;

  typedef enum logic {
    FIFO_EMPTY = 1'b0,
    FIFO_HOLD  = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/sb_rx_msg_fifo.sv
// First-word-fall-through message queue with occupancy counter and a sticky
// overflow flag; fullness is judged on the level before the clock edge.
module sb_rx_msg_fifo
  import sb_rx_msg_dispatcher_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             wr_accept;
  logic             pop;
  fifo_state_e      state;
  fifo_state_e      state_nxt;

  assign full      = (level == LW'(DEPTH));
  assign wr_accept = wr_en && !full && !flush;
  assign pop       = rd_valid && rd_ready && !flush;
  assign rd_valid  = (state == FIFO_HOLD);
  // Gate the head so the data outputs read 0 whenever the queue is empty.
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      case ({wr_accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FIFO_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FIFO_EMPTY: if (wr_accept) state_nxt = FIFO_HOLD;
      FIFO_HOLD: begin
        if (flush) begin
          state_nxt = FIFO_EMPTY;
        end else if (pop && !wr_accept && level == LW'(1)) begin
          state_nxt = FIFO_EMPTY;
        end
      end
      default: state_nxt = FIFO_EMPTY;
    endcase
  end

endmodule

// File: rtl/sb_rx_msg_dispatcher.sv
// Sideband receive dispatcher: routes decoded LTSM and RDI messages into two
// independent queues and counts messages dropped for parity errors.
module sb_rx_msg_dispatcher
  import sb_rx_msg_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = SB_PARITY_CNT_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_msg_valid,
  input  logic [SB_MSG_NO_W-1:0]        i_msg_no,
  input  logic [SB_MSG_INFO_W-1:0]      i_msg_info,
  input  logic [SB_DATA_W-1:0]          i_data,
  input  logic                          i_parity_error,
  input  logic                          i_rdi_msg_valid,
  input  logic [SB_RDI_CODE_W-1:0]      i_rdi_msg_code,
  input  logic [SB_RDI_SUB_CODE_W-1:0]  i_rdi_msg_sub_code,
  input  logic [SB_RDI_INFO_W-1:0]      i_rdi_msg_info,
  input  logic                          i_ltsm_ready,
  input  logic                          i_rdi_ready,
  output logic                          o_ltsm_valid,
  output logic [SB_MSG_NO_W-1:0]        o_ltsm_msg_no,
  output logic [SB_MSG_INFO_W-1:0]      o_ltsm_msg_info,
  output logic [SB_DATA_W-1:0]          o_ltsm_data,
  output logic                          o_rdi_valid,
  output logic [SB_RDI_CODE_W-1:0]      o_rdi_code,
  output logic [SB_RDI_SUB_CODE_W-1:0]  o_rdi_sub_code,
  output logic [SB_RDI_INFO_W-1:0]      o_rdi_info,
  output logic [$clog2(DEPTH):0]        o_ltsm_level,
  output logic [$clog2(DEPTH):0]        o_rdi_level,
  output logic                          o_ltsm_overflow,
  output logic                          o_rdi_overflow,
  output logic [CNT_W-1:0]              o_parity_drop_cnt
);

  ltsm_msg_t  ltsm_wr;
  ltsm_msg_t  ltsm_head;
  rdi_msg_t   rdi_wr;
  rdi_msg_t   rdi_head;
  logic       ltsm_drop;
  logic       rdi_drop;
  logic [1:0] drop_inc;
  logic [CNT_W:0] cnt_sum;

  assign ltsm_wr   = {i_msg_no, i_msg_info, i_data};
  assign rdi_wr    = {i_rdi_msg_code, i_rdi_msg_sub_code, i_rdi_msg_info};
  // The parity flag qualifies whichever messages are present this cycle.
  assign ltsm_drop = i_msg_valid && i_parity_error;
  assign rdi_drop  = i_rdi_msg_valid && i_parity_error;

  sb_rx_msg_fifo #(
    .WIDTH ($bits(ltsm_msg_t)),
    .DEPTH (DEPTH)
  ) u_ltsm_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .flush    (i_flush),
    .wr_en    (i_msg_valid && !i_parity_error),
    .wr_data  (ltsm_wr),
    .rd_ready (i_ltsm_ready),
    .rd_valid (o_ltsm_valid),
    .rd_data  (ltsm_head),
    .level    (o_ltsm_level),
    .overflow (o_ltsm_overflow)
  );

  sb_rx_msg_fifo #(
    .WIDTH ($bits(rdi_msg_t)),
    .DEPTH (DEPTH)
  ) u_rdi_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .flush    (i_flush),
    .wr_en    (i_rdi_msg_valid && !i_parity_error),
    .wr_data  (rdi_wr),
    .rd_ready (i_rdi_ready),
    .rd_valid (o_rdi_valid),
    .rd_data  (rdi_head),
    .level    (o_rdi_level),
    .overflow (o_rdi_overflow)
  );

  assign o_ltsm_msg_no   = ltsm_head.msg_no;
  assign o_ltsm_msg_info = ltsm_head.msg_info;
  assign o_ltsm_data     = ltsm_head.data;
  assign o_rdi_code      = rdi_head.code;
  assign o_rdi_sub_code  = rdi_head.sub_code;
  assign o_rdi_info      = rdi_head.info;

  // One extra sum bit catches the carry so the counter clamps at all-ones.
  assign drop_inc = {1'b0, ltsm_drop} + {1'b0, rdi_drop};
  assign cnt_sum  = {1'b0, o_parity_drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_parity_drop_cnt <= '0;
    end else if (i_flush) begin
      o_parity_drop_cnt <= '0;
    end else if (cnt_sum[CNT_W]) begin
      o_parity_drop_cnt <= '1;
    end else begin
      o_parity_drop_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_sb_rx_msg_dispatcher.sv
// Directed self-checking bench for sb_rx_msg_dispatcher (DEPTH=4, CNT_W=8).
module tb_sb_rx_msg_dispatcher;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_msg_valid = 1'b0;
  logic [3:0]  i_msg_no = '0;
  logic [2:0]  i_msg_info = '0;
  logic [15:0] i_data = '0;
  logic        i_parity_error = 1'b0;
  logic        i_rdi_msg_valid = 1'b0;
  logic [1:0]  i_rdi_msg_code = '0;
  logic [3:0]  i_rdi_msg_sub_code = '0;
  logic [1:0]  i_rdi_msg_info = '0;
  logic        i_ltsm_ready = 1'b0;
  logic        i_rdi_ready = 1'b0;
  logic        o_ltsm_valid;
  logic [3:0]  o_ltsm_msg_no;
  logic [2:0]  o_ltsm_msg_info;
  logic [15:0] o_ltsm_data;
  logic        o_rdi_valid;
  logic [1:0]  o_rdi_code;
  logic [3:0]  o_rdi_sub_code;
  logic [1:0]  o_rdi_info;
  logic [2:0]  o_ltsm_level;
  logic [2:0]  o_rdi_level;
  logic        o_ltsm_overflow;
  logic        o_rdi_overflow;
  logic [7:0]  o_parity_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  sb_rx_msg_dispatcher #(.DEPTH(4), .CNT_W(8)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_flush            (i_flush),
    .i_msg_valid        (i_msg_valid),
    .i_msg_no           (i_msg_no),
    .i_msg_info         (i_msg_info),
    .i_data             (i_data),
    .i_parity_error     (i_parity_error),
    .i_rdi_msg_valid    (i_rdi_msg_valid),
    .i_rdi_msg_code     (i_rdi_msg_code),
    .i_rdi_msg_sub_code (i_rdi_msg_sub_code),
    .i_rdi_msg_info     (i_rdi_msg_info),
    .i_ltsm_ready       (i_ltsm_ready),
    .i_rdi_ready        (i_rdi_ready),
    .o_ltsm_valid       (o_ltsm_valid),
    .o_ltsm_msg_no      (o_ltsm_msg_no),
    .o_ltsm_msg_info    (o_ltsm_msg_info),
    .o_ltsm_data        (o_ltsm_data),
    .o_rdi_valid        (o_rdi_valid),
    .o_rdi_code         (o_rdi_code),
    .o_rdi_sub_code     (o_rdi_sub_code),
    .o_rdi_info         (o_rdi_info),
    .o_ltsm_level       (o_ltsm_level),
    .o_rdi_level        (o_rdi_level),
    .o_ltsm_overflow    (o_ltsm_overflow),
    .o_rdi_overflow     (o_rdi_overflow),
    .o_parity_drop_cnt  (o_parity_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
  endtask

  task automatic ltsm_write(input logic [3:0] no, input logic perr);
    i_msg_valid    = 1'b1;
    i_msg_no       = no;
    i_msg_info     = no[2:0];
    i_data         = {4{no}};
    i_parity_error = perr;
    step();
    i_msg_valid    = 1'b0;
    i_parity_error = 1'b0;
  endtask

  task automatic rdi_write(input logic [1:0] code, input logic [3:0] sub);
    i_rdi_msg_valid    = 1'b1;
    i_rdi_msg_code     = code;
    i_rdi_msg_sub_code = sub;
    i_rdi_msg_info     = code;
    step();
    i_rdi_msg_valid    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (o_ltsm_valid !== 1'b0 || o_rdi_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b/%b expected 0/0", o_ltsm_valid, o_rdi_valid);
    else n_pass++;
    n_checks++;
    if (o_ltsm_level !== 3'd0 || o_rdi_level !== 3'd0) $display("[TB] FAIL reset_level: got %0d/%0d expected 0/0", o_ltsm_level, o_rdi_level);
    else n_pass++;
    n_checks++;
    if (o_ltsm_overflow !== 1'b0 || o_rdi_overflow !== 1'b0 || o_parity_drop_cnt !== 8'd0)
      $display("[TB] FAIL reset_flags: got %b/%b cnt %0d expected 0/0 cnt 0", o_ltsm_overflow, o_rdi_overflow, o_parity_drop_cnt);
    else n_pass++;
    n_checks++;
    if (o_ltsm_data !== 16'd0 || o_rdi_code !== 2'd0) $display("[TB] FAIL reset_data: got %h/%0d expected 0/0", o_ltsm_data, o_rdi_code);
    else n_pass++;
    step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_fifo_order();
    i_ltsm_ready = 1'b0;
    for (int k = 1; k <= 3; k++) ltsm_write(4'(k), 1'b0);
    n_checks++;
    if (o_ltsm_level !== 3'd3) $display("[TB] FAIL order_level: got %0d expected 3", o_ltsm_level);
    else n_pass++;
    step();
    n_checks++;
    if (o_ltsm_valid !== 1'b1 || o_ltsm_msg_no !== 4'd1) $display("[TB] FAIL order_hold: got v=%b no=%0d expected v=1 no=1", o_ltsm_valid, o_ltsm_msg_no);
    else n_pass++;
    i_ltsm_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (o_ltsm_valid !== 1'b1 || o_ltsm_msg_no !== 4'(k) || o_ltsm_data !== {4{4'(k)}})
        $display("[TB] FAIL order_head%0d: got v=%b no=%0d data=%h expected v=1 no=%0d", k, o_ltsm_valid, o_ltsm_msg_no, o_ltsm_data, k);
      else n_pass++;
      step();
    end
    i_ltsm_ready = 1'b0;
    n_checks++;
    if (o_ltsm_valid !== 1'b0 || o_ltsm_level !== 3'd0) $display("[TB] FAIL order_empty: got v=%b level=%0d expected 0/0", o_ltsm_valid, o_ltsm_level);
    else n_pass++;
  endtask

  task automatic test_simul_wr_pop();
    do_flush();
    ltsm_write(4'd10, 1'b0);
    ltsm_write(4'd11, 1'b0);
    i_ltsm_ready = 1'b1;
    ltsm_write(4'd12, 1'b0);
    i_ltsm_ready = 1'b0;
    n_checks++;
    if (o_ltsm_level !== 3'd2 || o_ltsm_msg_no !== 4'd11) $display("[TB] FAIL simul_wr_pop: got level=%0d no=%0d expected 2/11", o_ltsm_level, o_ltsm_msg_no);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_flush();
    for (int k = 4; k <= 7; k++) ltsm_write(4'(k), 1'b0);
    n_checks++;
    if (o_ltsm_level !== 3'd4 || o_ltsm_overflow !== 1'b0) $display("[TB] FAIL ovf_full: got level=%0d ovf=%b expected 4/0", o_ltsm_level, o_ltsm_overflow);
    else n_pass++;
    i_ltsm_ready = 1'b1;
    ltsm_write(4'd8, 1'b0);
    n_checks++;
    if (o_ltsm_level !== 3'd3 || o_ltsm_overflow !== 1'b1 || o_ltsm_msg_no !== 4'd5)
      $display("[TB] FAIL ovf_drop: got level=%0d ovf=%b no=%0d expected 3/1/5", o_ltsm_level, o_ltsm_overflow, o_ltsm_msg_no);
    else n_pass++;
    for (int k = 5; k <= 7; k++) step();
    i_ltsm_ready = 1'b0;
    n_checks++;
    if (o_ltsm_valid !== 1'b0 || o_ltsm_overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got v=%b ovf=%b expected 0/1", o_ltsm_valid, o_ltsm_overflow);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic saw_valid;
    saw_valid = 1'b0;
    do_flush();
    for (int i = 0; i < 300; i++) begin
      ltsm_write(4'(i), 1'b1);
      if (o_ltsm_valid !== 1'b0) saw_valid = 1'b1;
      if (i == 0) begin
        n_checks++;
        if (o_parity_drop_cnt !== 8'd1) $display("[TB] FAIL parity_first: got %0d expected 1", o_parity_drop_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (o_parity_drop_cnt !== 8'd255) $display("[TB] FAIL parity_sat: got %0d expected 255", o_parity_drop_cnt);
    else n_pass++;
    n_checks++;
    if (saw_valid !== 1'b0 || o_ltsm_level !== 3'd0 || o_ltsm_overflow !== 1'b0)
      $display("[TB] FAIL parity_nowrite: got saw_valid=%b level=%0d ovf=%b expected 0/0/0", saw_valid, o_ltsm_level, o_ltsm_overflow);
    else n_pass++;
    do_flush();
    i_msg_valid = 1'b1;
    i_rdi_msg_valid = 1'b1;
    i_parity_error = 1'b1;
    step();
    i_msg_valid = 1'b0;
    i_rdi_msg_valid = 1'b0;
    i_parity_error = 1'b0;
    n_checks++;
    if (o_parity_drop_cnt !== 8'd2 || o_rdi_valid !== 1'b0) $display("[TB] FAIL parity_dual: got cnt=%0d rdi_v=%b expected 2/0", o_parity_drop_cnt, o_rdi_valid);
    else n_pass++;
  endtask

  task automatic test_dual_channel();
    do_flush();
    i_msg_valid = 1'b1;
    i_msg_no = 4'd9;
    i_rdi_msg_valid = 1'b1;
    i_rdi_msg_code = 2'd2;
    i_rdi_msg_sub_code = 4'd5;
    i_rdi_msg_info = 2'd1;
    step();
    i_msg_valid = 1'b0;
    i_rdi_msg_valid = 1'b0;
    n_checks++;
    if (o_ltsm_level !== 3'd1 || o_rdi_level !== 3'd1) $display("[TB] FAIL dual_level: got %0d/%0d expected 1/1", o_ltsm_level, o_rdi_level);
    else n_pass++;
    n_checks++;
    if (o_rdi_code !== 2'd2 || o_rdi_sub_code !== 4'd5 || o_rdi_info !== 2'd1 || o_ltsm_msg_no !== 4'd9)
      $display("[TB] FAIL dual_fields: got code=%0d sub=%0d info=%0d no=%0d expected 2/5/1/9", o_rdi_code, o_rdi_sub_code, o_rdi_info, o_ltsm_msg_no);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_flush();
    ltsm_write(4'd1, 1'b1);
    for (int k = 0; k < 5; k++) rdi_write(2'(k), 4'(k));
    ltsm_write(4'd2, 1'b0);
    ltsm_write(4'd3, 1'b0);
    n_checks++;
    if (o_rdi_overflow !== 1'b1 || o_ltsm_level !== 3'd2 || o_parity_drop_cnt !== 8'd1)
      $display("[TB] FAIL flush_pre: got rdi_ovf=%b level=%0d cnt=%0d expected 1/2/1", o_rdi_overflow, o_ltsm_level, o_parity_drop_cnt);
    else n_pass++;
    i_flush = 1'b1;
    i_ltsm_ready = 1'b1;
    ltsm_write(4'd4, 1'b0);
    i_flush = 1'b0;
    i_ltsm_ready = 1'b0;
    n_checks++;
    if (o_ltsm_level !== 3'd0 || o_rdi_level !== 3'd0 || o_ltsm_valid !== 1'b0 || o_rdi_valid !== 1'b0)
      $display("[TB] FAIL flush_clear: got levels %0d/%0d valids %b/%b expected 0", o_ltsm_level, o_rdi_level, o_ltsm_valid, o_rdi_valid);
    else n_pass++;
    n_checks++;
    if (o_rdi_overflow !== 1'b0 || o_ltsm_overflow !== 1'b0 || o_parity_drop_cnt !== 8'd0)
      $display("[TB] FAIL flush_flags: got %b/%b cnt=%0d expected 0/0/0", o_ltsm_overflow, o_rdi_overflow, o_parity_drop_cnt);
    else n_pass++;
    step();
    n_checks++;
    if (o_ltsm_valid !== 1'b0) $display("[TB] FAIL flush_discard: got v=%b expected 0", o_ltsm_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_flush();
    for (int k = 1; k <= 3; k++) ltsm_write(4'(k), 1'b0);
    i_ltsm_ready = 1'b1;
    step();
    n_checks++;
    if (o_ltsm_level !== 3'd2) $display("[TB] FAIL rstmid_pre: got level=%0d expected 2", o_ltsm_level);
    else n_pass++;
    #3;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_ltsm_valid !== 1'b0 || o_ltsm_level !== 3'd0 || o_ltsm_msg_no !== 4'd0 || o_ltsm_data !== 16'd0)
      $display("[TB] FAIL rstmid_async: got v=%b level=%0d no=%0d data=%h expected 0", o_ltsm_valid, o_ltsm_level, o_ltsm_msg_no, o_ltsm_data);
    else n_pass++;
    i_ltsm_ready = 1'b0;
    step();
    i_rst = 1'b0;
    step();
    n_checks++;
    if (o_ltsm_valid !== 1'b0) $display("[TB] FAIL rstmid_noreplay: got v=%b expected 0", o_ltsm_valid);
    else n_pass++;
    ltsm_write(4'd12, 1'b0);
    n_checks++;
    if (o_ltsm_valid !== 1'b1 || o_ltsm_msg_no !== 4'd12 || o_ltsm_level !== 3'd1)
      $display("[TB] FAIL rstmid_new: got v=%b no=%0d level=%0d expected 1/12/1", o_ltsm_valid, o_ltsm_msg_no, o_ltsm_level);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_simul_wr_pop();
    test_overflow();
    test_parity();
    test_dual_channel();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
